// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and frame builder for the PS/2 digit transmitter.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;

  localparam logic [7:0] SC_DIG0 = 8'h45;
  localparam logic [7:0] SC_DIG1 = 8'h16;
  localparam logic [7:0] SC_DIG2 = 8'h1E;
  localparam logic [7:0] SC_DIG3 = 8'h26;
  localparam logic [7:0] SC_DIG4 = 8'h25;
  localparam logic [7:0] SC_DIG5 = 8'h2E;
  localparam logic [7:0] SC_DIG6 = 8'h36;
  localparam logic [7:0] SC_DIG7 = 8'h3D;
  localparam logic [7:0] SC_DIG8 = 8'h3E;
  localparam logic [7:0] SC_DIG9 = 8'h46;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Frame in transmit order from bit 0: start, data LSB first, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] code);
    return {1'b1, ~^code, code, 1'b0};
  endfunction

endpackage

// File: rtl/dec2ps2_tx_dec2key.sv
// Combinational decimal digit to Set-2 make-code lookup with a legal flag.
module dec2key
  import ps2_pkg::*;
(
  input  logic [7:0] dec,
  output logic [7:0] code,
  output logic       legal
);

  // Digit lookup; anything above 9 is flagged illegal.
  always_comb begin
    code  = 8'h00;
    legal = 1'b1;
    case (dec)
      8'd0:    code = SC_DIG0;
      8'd1:    code = SC_DIG1;
      8'd2:    code = SC_DIG2;
      8'd3:    code = SC_DIG3;
      8'd4:    code = SC_DIG4;
      8'd5:    code = SC_DIG5;
      8'd6:    code = SC_DIG6;
      8'd7:    code = SC_DIG7;
      8'd8:    code = SC_DIG8;
      8'd9:    code = SC_DIG9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dec2ps2_tx.sv
// PS/2 keyboard-side transmitter: sends the Set-2 keystroke for a decimal digit.
// Define PS2_BREAK_EN to append the break sequence (F0 prefix plus code).
module dec2ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2500,
  parameter int unsigned GAP_DIV = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dec,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(FRAME_BITS - 1);
`ifdef PS2_BREAK_EN
  localparam int unsigned FRM_W = 2;
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_DIV - 1);
  localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(2);
`endif

  state_t                  state_q, state_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic [IDX_W-1:0]        idx_q, idx_n;
  logic [FRAME_BITS-1:0]   sh_q, sh_n;
`ifdef PS2_BREAK_EN
  logic [FRM_W-1:0]        frm_q, frm_n;
  logic [7:0]              code_q, code_n;
`endif
  logic                    clk_n, data_n, ready_n, busy_n, done_n, err_n;
  logic [7:0]              key_code;
  logic                    key_legal;

  dec2key u_dec2key (
    .dec   (dec),
    .code  (key_code),
    .legal (key_legal)
  );

  // State, counters, shift register and registered line/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '1;
`ifdef PS2_BREAK_EN
      frm_q    <= '0;
      code_q   <= '0;
`endif
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      sh_q     <= sh_n;
`ifdef PS2_BREAK_EN
      frm_q    <= frm_n;
      code_q   <= code_n;
`endif
      ps2_clk  <= clk_n;
      ps2_data <= data_n;
      ready    <= ready_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  // Next-state sequencing; line levels follow from the next state and frame bit.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    sh_n    = sh_q;
`ifdef PS2_BREAK_EN
    frm_n   = frm_q;
    code_n  = code_q;
`endif
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (key_legal) begin
            sh_n    = make_frame(key_code);
            cnt_n   = '0;
            idx_n   = '0;
`ifdef PS2_BREAK_EN
            frm_n   = '0;
            code_n  = key_code;
`endif
            state_n = BIT_HI;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      BIT_HI: begin
        if (cnt_q == HALF_LAST) begin
          cnt_n   = '0;
          state_n = BIT_LO;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      BIT_LO: begin
        if (cnt_q == HALF_LAST) begin
          cnt_n = '0;
          if (idx_q != BIT_LAST) begin
            idx_n   = idx_q + IDX_W'(1);
            sh_n    = {1'b1, sh_q[FRAME_BITS-1:1]};
            state_n = BIT_HI;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
`ifdef PS2_BREAK_EN
            if (frm_q != FRAME_LAST) begin
              frm_n   = frm_q + FRM_W'(1);
              state_n = GAP;
              done_n  = 1'b0;
            end
`endif
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
`ifdef PS2_BREAK_EN
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          sh_n    = make_frame((frm_q == FRM_W'(1)) ? BREAK_PREFIX : code_q);
          state_n = BIT_HI;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    clk_n   = (state_n != BIT_LO);
    data_n  = (state_n == BIT_HI || state_n == BIT_LO) ? sh_n[0] : 1'b1;
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

endmodule

// File: tb/tb_dec2ps2_tx.sv
// Directed self-checking bench for dec2ps2_tx (CLK_DIV=4, GAP_DIV=8).
module tb_dec2ps2_tx;

  localparam int unsigned CD = 4;
  localparam int unsigned GD = 8;
`ifdef PS2_BREAK_EN
  localparam int NF     = 3;
  localparam int KLEN   = 66 * CD + 2 * GD;
  localparam int MAXRUN = GD;
`else
  localparam int NF     = 1;
  localparam int KLEN   = 22 * CD;
  localparam int MAXRUN = CD;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dec = 8'd0;
  logic       valid = 1'b0;
  logic       ready, busy, done, err, ps2_clk, ps2_data;

  int total = 0;
  int bad   = 0;

  dec2ps2_tx #(.CLK_DIV(CD), .GAP_DIV(GD)) dut (
    .clk      (clk),
    .rst      (rst),
    .dec      (dec),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first cycle after a handshake; returns at the done cycle.
  task automatic run_key(input string tag, input logic [7:0] code, input int drop_at);
    logic [32:0] bits;
    logic [10:0] fb;
    logic [7:0]  exp_code;
    logic        prev;
    int          nb, cyc, run, maxrun;
    bit          seen;
    bits = '0; nb = 0; cyc = 1; run = 0; maxrun = 0; prev = 1'b1; seen = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_ready"}, 32'(ready), 32'd0);
    chk({tag, "_start_clk"}, 32'(ps2_clk), 32'd1);
    chk({tag, "_start_data"}, 32'(ps2_data), 32'd0);
    while (cyc < 2000 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (prev && !ps2_clk && nb < 33) begin
          bits[nb] = ps2_data;
          nb++;
        end
        if (ps2_clk && ps2_data) begin
          run++;
          if (run > maxrun) maxrun = run;
        end else begin
          run = 0;
        end
        prev = ps2_clk;
        if (cyc == drop_at) valid = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_length"}, 32'(cyc - 1), 32'(KLEN));
    chk({tag, "_done_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_high_run"}, 32'(maxrun), 32'(MAXRUN));
    chk({tag, "_nbits"}, 32'(nb), 32'(11 * NF));
    for (int f = 0; f < NF; f++) begin
      fb = bits[f*11 +: 11];
      exp_code = (f == 1) ? 8'hF0 : code;
      chk({tag, "_start_bit"}, 32'(fb[0]), 32'd0);
      chk({tag, "_code"}, 32'(fb[8:1]), 32'(exp_code));
      chk({tag, "_odd_parity"}, 32'(^fb[9:1]), 32'd1);
      chk({tag, "_stop_bit"}, 32'(fb[10]), 32'd1);
    end
  endtask

  initial begin
    int n;

    // Reset values while reset is held
    @(negedge clk);
    chk("rst_clk", 32'(ps2_clk), 32'd1);
    chk("rst_data", 32'(ps2_data), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Digit 1 -> 16
    dec = 8'd1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    run_key("d1", 8'h16, 0);
    @(negedge clk);
    chk("d1_done_pulse", 32'(done), 32'd0);

    // Digit 2 -> 1E
    dec = 8'd2; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    run_key("d2", 8'h1E, 0);
    @(negedge clk);

    // Illegal digit 12
    dec = 8'd12; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_ready", 32'(ready), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_clk", 32'(ps2_clk), 32'd1);
    chk("ill_data", 32'(ps2_data), 32'd1);
    @(negedge clk);
    chk("ill_err_pulse", 32'(err), 32'd0);
    n = 0;
    repeat (100) begin
      if (done || err || !ps2_clk || !ps2_data || !ready) n++;
      @(negedge clk);
    end
    chk("ill_quiet", 32'(n), 32'd0);

    // Back-to-back 0 then 9 with valid held high
    dec = 8'd0; valid = 1'b1;
    @(negedge clk);
    dec = 8'd9;
    run_key("b2b0", 8'h45, 100000);
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done), 32'd0);
    run_key("b2b9", 8'h46, 1);
    @(negedge clk);

    // Reset in the middle of a frame (cycle 30 is a low phase)
    dec = 8'd3; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_clk_low", 32'(ps2_clk), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_clk", 32'(ps2_clk), 32'd1);
    chk("mid_rst_data", 32'(ps2_data), 32'd1);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (200) begin
      if (done || busy || !ps2_clk || !ps2_data) n++;
      @(negedge clk);
    end
    chk("mid_no_done", 32'(n), 32'd0);
    dec = 8'd5; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    run_key("d5", 8'h2E, 0);
    @(negedge clk);

    // dec and valid change while busy; captured digit 4 -> 25 must be sent
    dec = 8'd4; valid = 1'b1;
    @(negedge clk);
    dec = 8'd7;
    run_key("hold", 8'h25, 20);
    @(negedge clk);
    chk("hold_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
